// File: rtl/comb_path_stress.sv
// comb_path_stress: twin DEPTH-stage mixing paths driven by one stimulus; mismatches flag timing failure.
module comb_path_stress_mix #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PIPE_EVERY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] st [0:DEPTH];
  assign st[0] = x;
  genvar k;
  for (k = 0; k < DEPTH; k++) begin : g_stg
    localparam logic [63:0] CK = 64'(k + 1) * 64'h9E37_79B9;
    logic [WIDTH-1:0] m;
    assign m = {st[k][WIDTH-2:0], st[k][WIDTH-1]} ^ (st[k] + CK[WIDTH-1:0]);
    if (PIPE_EVERY != 0 && (k + 1) % PIPE_EVERY == 0 && k + 1 < DEPTH) begin : g_reg
      logic [WIDTH-1:0] q;
      always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else q <= m;
      assign st[k+1] = q;
    end else begin : g_cmb
      assign st[k+1] = m;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) y <= '0;
    else y <= st[DEPTH];
endmodule

module comb_path_stress #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PIPE_EVERY = 0,
  parameter int RUN_CYCLES = 1048576,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             inject_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] sig_o
);
  localparam int L = 1 + (PIPE_EVERY == 0 ? 0 : (DEPTH - 1) / PIPE_EVERY);
  localparam int CW = $clog2(RUN_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] s, in_b;
  logic [CW-1:0] cnt;
  logic [L-1:0] v, v_nxt;
  logic issue;
  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] out_a;
  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] out_b;
  assign issue = state == RUN;
  assign in_b = s ^ WIDTH'(inject_i & issue);
  if (L == 1) begin : g_v1
    assign v_nxt = issue;
  end else begin : g_vn
    assign v_nxt = {v[L-2:0], issue};
  end
  (* keep_hierarchy = "yes", dont_touch = "true" *)
  comb_path_stress_mix #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PIPE_EVERY(PIPE_EVERY)) u_path_a (
    .clk(clk), .rst(rst), .x(s), .y(out_a));
  (* keep_hierarchy = "yes", dont_touch = "true" *)
  comb_path_stress_mix #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PIPE_EVERY(PIPE_EVERY)) u_path_b (
    .clk(clk), .rst(rst), .x(in_b), .y(out_b));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s <= '0;
      cnt <= '0;
      v <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      err_cnt_o <= '0;
      sig_o <= '0;
    end else begin
      v <= v_nxt;
      if (v[L-1]) begin
        sig_o <= {sig_o[WIDTH-2:0], sig_o[WIDTH-1]} ^ out_a;
        if (out_a != out_b) begin
          err_o <= 1'b1;
          if (~&err_cnt_o) err_cnt_o <= err_cnt_o + 1'b1;
        end
      end
      case (state)
        IDLE, DONE: if (start_i) begin
          state <= RUN;
          s <= seed_i;
          cnt <= '0;
          err_o <= 1'b0;
          err_cnt_o <= '0;
          sig_o <= '0;
          busy_o <= 1'b1;
          done_o <= 1'b0;
        end
        RUN: begin
          s <= s + 1'b1;
          cnt <= cnt + 1'b1;
          if (stop_i || cnt == CW'(RUN_CYCLES - 1)) state <= DRAIN;
        end
        default: if (v_nxt == '0) begin
          state <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
      endcase
    end
  end
endmodule
